header_word_packer: RTL
=======================

# header_word_packer

Downstream consumer of the 16-bit FWFT width-converting FIFO in the oBTC miner datapath. It pops 16-bit words from the FIFO and assembles WORDS consecutive words into one wide work frame, such as the 640-bit block header. It presents the frame to the hash core over a valid/ready handshake. A single frame register is used: the block stops popping while a frame is held.

## Interface
- DWIDTH, 16, FIFO word width; must equal the FIFO DOUTWIDTH.
- WORDS, 40, words per frame; must be ≥ 2.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- fifo_dout  in  DWIDTH  FIFO head word; valid while fifo_empty=0 (FWFT).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe to the FIFO; combinational.
- flush  in  1  discard the partial or held frame.
- work_data  out  WORDS*DWIDTH  assembled frame.
- work_valid  out  1  frame valid.
- work_ready  in  1  consumer accepts the frame.
- frame_cnt  out  32  frames handed off since reset; wraps at 2^32.
- busy  out  1  high when word count ≠ 0 or state is HOLD.

## Operation
- States: FILL, HOLD. Reset state is FILL.
- fifo_rd_en = (state==FILL) & ~fifo_empty & ~flush & ~rst.
- FILL, on a pop:
  - shift left: work_data <= {work_data[(WORDS-1)*DWIDTH-1:0], word}.
  - The first popped word ends in the MS slot [WORDS*DWIDTH-1 -: DWIDTH].
  - The last popped word ends in the LS slot.
  - wcnt increments.
- FILL, on the pop with wcnt==WORDS-1:
  - wcnt <= 0, state <= HOLD, work_valid <= 1.
- HOLD:
  - fifo_rd_en=0.
  - work_data and work_valid are stable until the handshake.
  - On work_valid & work_ready: work_valid <= 0, frame_cnt++, state <= FILL.
- flush, any state:
  - wcnt <= 0, state <= FILL, work_valid <= 0.
  - work_data is not cleared; its content is don't-care until the next frame.
- flush and a handshake in the same HOLD cycle: the handshake completes and frame_cnt increments; flush then has nothing to discard.
- fifo_empty in mid-FILL: the block waits indefinitely and keeps wcnt; no timeout.
- wcnt width: $clog2(WORDS). frame_cnt is a 32-bit unsigned counter that wraps.
- Reset values:
  - work_valid=0, work_data=0, frame_cnt=0, busy=0, fifo_rd_en=0.
  - Internal: state=FILL, wcnt=0.
- Reset mid-frame or mid-HOLD: the frame is lost and no handshake completes. Words already popped are not restored to the FIFO.

## Timing
- Pop-to-store latency is 0 cycles. The word is captured on the same edge that pops it, because the FIFO is FWFT.
- With the FIFO never empty and the first pop in cycle 0:
  - the last pop is in cycle WORDS-1;
  - work_valid is high from cycle WORDS.
- Handshake in cycle H: work_valid is low in H+1 and the next pop is possible in H+1.
- Sustained throughput with work_ready held high: one frame per WORDS+1 cycles.
- All outputs except fifo_rd_en are registered.

## Configuration
- BYTE_SWAP_WORDS_EN defined: each popped word has its two bytes swapped before storage, i.e. {w[7:0], w[15:8]}. This converts host little-endian order for SHA-256. Requires DWIDTH=16; otherwise an elaboration error is raised.
- Undefined: words are stored unmodified.
- Word order within the frame is unaffected in both cases.

## Structure
- Shared package miner_pkg holds:
  - packer_state_t enum {FILL, HOLD};
  - HEADER_WORDS=40 and WORD_W=16 constants;
  - function bswap16.
- No sub-module. The block is one always_ff for state, wcnt, frame and counters, plus one always_comb for fifo_rd_en.

## Test plan
- Streaming, WORDS=4: FIFO holds 0x0001,0x0002,0x0003,0x0004, work_ready=1 → work_data=0x0001_0002_0003_0004, valid in cycle 4, frame_cnt=1.
- Backpressure: frame held with work_ready=0 for 10 cycles while the FIFO has 8 words → fifo_rd_en=0 and work_data stable throughout; after ready the next frame is 5..8.
- Gaps: fifo_empty toggles every other cycle, WORDS=40 → one frame after 40 pops with correct order, and no pop while empty.
- flush after 2 of 4 words, then words A,B,C,D → frame=ABCD, busy=0 in the cycle after flush.
- Reset while in HOLD → work_valid=0 and frame_cnt=0 the next cycle; no pop during rst.
- BYTE_SWAP_WORDS_EN, input 0x1234 → stored 0x3412. With the macro undefined → 0x1234.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared miner types, constants and helpers.
// Byte-swap helper is used when BYTE_SWAP_WORDS_EN is defined.
package miner_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  localparam int HEADER_WORDS = 40;
  localparam int WORD_W       = 16;

  function automatic logic [15:0] bswap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/header_word_packer.sv
// Packs FWFT FIFO words into one wide work frame with valid/ready handoff.
// Optional BYTE_SWAP_WORDS_EN swaps the bytes of each 16-bit word.
module header_word_packer
  import miner_pkg::*;
#(
  parameter int DWIDTH = WORD_W,
  parameter int WORDS  = HEADER_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DWIDTH-1:0]       fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic                    flush,
  output logic [WORDS*DWIDTH-1:0] work_data,
  output logic                    work_valid,
  input  logic                    work_ready,
  output logic [31:0]             frame_cnt,
  output logic                    busy
);

  localparam int CW = $clog2(WORDS);

  packer_state_t             r_state;
  logic [CW-1:0]             r_wcnt;
  logic [WORDS*DWIDTH-1:0]   r_data;
  logic                      r_valid;
  logic [31:0]               r_cnt;
  logic [DWIDTH-1:0]         w_word;
  logic                      w_pop;
  logic                      w_hs;

`ifdef BYTE_SWAP_WORDS_EN
  if (DWIDTH != 16) begin : g_bad_width
    $error("BYTE_SWAP_WORDS_EN needs DWIDTH=16");
  end
  assign w_word = DWIDTH'(bswap16(fifo_dout[15:0]));
`else
  assign w_word = fifo_dout;
`endif

  always_comb begin
    w_pop = (r_state == FILL) & ~fifo_empty
          & ~flush & ~rst;
  end

  assign fifo_rd_en = w_pop;
  assign w_hs       = (r_state == HOLD) & r_valid
                    & work_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_wcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_hs) begin
      // Handshake wins over a same-cycle flush.
      r_valid <= 1'b0;
      r_cnt   <= r_cnt + 32'd1;
      r_state <= FILL;
      r_wcnt  <= '0;
    end else if (flush) begin
      r_wcnt  <= '0;
      r_state <= FILL;
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_data <= {r_data[(WORDS-1)*DWIDTH-1:0],
                 w_word};
      if (r_wcnt == CW'(WORDS - 1)) begin
        r_wcnt  <= '0;
        r_state <= HOLD;
        r_valid <= 1'b1;
      end else begin
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  assign work_data  = r_data;
  assign work_valid = r_valid;
  assign frame_cnt  = r_cnt;
  assign busy       = (r_wcnt != '0) |
                      (r_state == HOLD);

endmodule
